// File: rtl/page_table_walker_pkg.sv
// Shared types and helpers for the Sv39 page-table walker.
package page_table_walker_pkg;

  localparam int unsigned SV39_LEVELS = 3;
  localparam int unsigned PTE_BYTES   = 8;
  localparam int unsigned PTE_SHIFT   = $clog2(PTE_BYTES);

  typedef struct packed {
    logic [9:0]  rsvd;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {
    PTW_IDLE,
    PTW_REQ,
    PTW_WAIT,
    PTW_DONE,
    PTW_DRAIN
  } ptw_state_e;

  typedef enum logic {
    REQ_IF,
    REQ_MEM
  } req_id_e;

  // Superpage leaves take their low PPN bits from the VPN.
  function automatic logic [43:0] compose_ppn(input logic [43:0] ppn,
                                              input logic [26:0] vpn,
                                              input logic [1:0]  lvl);
    case (lvl)
      2'd2:    compose_ppn = {ppn[43:18], vpn[17:0]};
      2'd1:    compose_ppn = {ppn[43:9],  vpn[8:0]};
      default: compose_ppn = ppn;
    endcase
  endfunction

  function automatic logic misaligned(input logic [43:0] ppn, input logic [1:0] lvl);
    case (lvl)
      2'd2:    misaligned = |ppn[17:0];
      2'd1:    misaligned = |ppn[8:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/page_table_walker_rr_arbiter.sv
// Two-way round-robin grant between the fetch and data requesters.
module ptw_rr_arbiter
  import page_table_walker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_valid,
  input  logic mem_valid,
  output logic if_grant,
  output logic mem_grant
);

  req_id_e last;
  logic    both;

  // A requester is only held off when the other one is also asking and is due.
  always_comb begin
    both      = if_valid & mem_valid;
    if_grant  = en & ~(both & (last == REQ_IF));
    mem_grant = en & ~(both & (last == REQ_MEM));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= REQ_MEM;
    end else if (if_valid & if_grant) begin
      last <= REQ_IF;
    end else if (mem_valid & mem_grant) begin
      last <= REQ_MEM;
    end
  end

endmodule

// File: rtl/page_table_walker.sv
// Sv39 page-table walker: arbitrates IF/MEM misses and walks three levels
// through a single read port, returning the leaf PTE and composed PPN.
module page_table_walker
  import page_table_walker_pkg::*;
#(
  parameter int unsigned PA_W  = 56,
  parameter int unsigned PPN_W = 44,
  parameter int unsigned VPN_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PPN_W-1:0] satp_ppn,
  input  logic             flush,
  input  logic             if_req_valid,
  input  logic [VPN_W-1:0] if_req_vpn,
  output logic             if_req_ready,
  input  logic             mem_req_valid,
  input  logic [VPN_W-1:0] mem_req_vpn,
  output logic             mem_req_ready,
  output logic             if_resp_valid,
  output logic             mem_resp_valid,
  output logic [63:0]      resp_pte,
  output logic [PPN_W-1:0] resp_ppn,
  output logic [1:0]       resp_level,
  output logic             resp_fault,
  output logic             rd_valid,
  output logic [63:0]      rd_addr,
  input  logic             rd_ready,
  input  logic             rd_data_valid,
  input  logic [63:0]      rd_data
);

  ptw_state_e       state, state_nxt;
  logic [VPN_W-1:0] vpn;
  logic [PPN_W-1:0] a_ppn;
  logic [1:0]       lvl;
  req_id_e          owner;

  pte_t       pte;
  logic       pte_leaf, pte_fault, pte_descend;
  logic [8:0] vpn_idx;
  logic       if_fire, mem_fire, accept, pte_take;

  ptw_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        ((state == PTW_IDLE) & ~flush),
    .if_valid  (if_req_valid),
    .mem_valid (mem_req_valid),
    .if_grant  (if_req_ready),
    .mem_grant (mem_req_ready)
  );

  always_comb begin
    if_fire  = if_req_valid & if_req_ready;
    mem_fire = mem_req_valid & mem_req_ready;
    accept   = if_fire | mem_fire;
    pte_take = (state == PTW_WAIT) & rd_data_valid & ~flush;
  end

  always_comb begin
    pte         = pte_t'(rd_data);
    pte_leaf    = pte.r | pte.x;
    pte_fault   = ~pte.v | (~pte.r & pte.w)
                | (pte_leaf & misaligned(pte.ppn, lvl))
                | (~pte_leaf & (lvl == 2'd0));
    pte_descend = ~pte_fault & ~pte_leaf;
  end

  always_comb begin
    case (lvl)
      2'd2:    vpn_idx = vpn[26:18];
      2'd1:    vpn_idx = vpn[17:9];
      default: vpn_idx = vpn[8:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PTW_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush coinciding with returning data needs no drain: that read is already consumed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      PTW_IDLE: begin
        if (accept) state_nxt = PTW_REQ;
      end
      PTW_REQ: begin
        if (rd_ready)   state_nxt = flush ? PTW_DRAIN : PTW_WAIT;
        else if (flush) state_nxt = PTW_IDLE;
      end
      PTW_WAIT: begin
        if (flush)              state_nxt = rd_data_valid ? PTW_IDLE : PTW_DRAIN;
        else if (rd_data_valid) state_nxt = pte_descend ? PTW_REQ : PTW_DONE;
      end
      PTW_DONE: state_nxt = PTW_IDLE;
      PTW_DRAIN: begin
        if (rd_data_valid) state_nxt = PTW_IDLE;
      end
      default: state_nxt = PTW_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpn        <= '0;
      a_ppn      <= '0;
      lvl        <= '0;
      owner      <= REQ_IF;
      resp_pte   <= '0;
      resp_ppn   <= '0;
      resp_level <= '0;
      resp_fault <= 1'b0;
    end else if (accept) begin
      vpn   <= if_fire ? if_req_vpn : mem_req_vpn;
      a_ppn <= satp_ppn;
      lvl   <= 2'(SV39_LEVELS - 1);
      owner <= if_fire ? REQ_IF : REQ_MEM;
    end else if (pte_take) begin
      if (pte_descend) begin
        a_ppn <= pte.ppn;
        lvl   <= lvl - 2'd1;
      end else begin
        resp_pte   <= pte;
        resp_ppn   <= compose_ppn(pte.ppn, vpn, lvl);
        resp_level <= lvl;
        resp_fault <= pte_fault;
      end
    end
  end

  always_comb begin
    rd_valid       = (state == PTW_REQ);
    rd_addr        = '0;
    if (state == PTW_REQ) begin
      rd_addr[PA_W-1:0] = {a_ppn, vpn_idx, {PTE_SHIFT{1'b0}}};
    end
    if_resp_valid  = (state == PTW_DONE) & ~flush & (owner == REQ_IF);
    mem_resp_valid = (state == PTW_DONE) & ~flush & (owner == REQ_MEM);
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Randomised bench for page_table_walker against an arithmetic Sv39 walk model.
module tb_page_table_walker;

  localparam logic [43:0] ROOT = 44'h123;

  logic        clk = 1'b0;
  logic        rst;
  logic [43:0] satp_ppn;
  logic        flush;
  logic        if_req_valid, mem_req_valid;
  logic [26:0] if_req_vpn, mem_req_vpn;
  logic        if_req_ready, mem_req_ready;
  logic        if_resp_valid, mem_resp_valid;
  logic [63:0] resp_pte;
  logic [43:0] resp_ppn;
  logic [1:0]  resp_level;
  logic        resp_fault;
  logic        rd_valid;
  logic [63:0] rd_addr;
  logic        rd_ready;
  logic        rd_data_valid;
  logic [63:0] rd_data;

  page_table_walker #(.PA_W(56), .PPN_W(44), .VPN_W(27)) dut (
    .clk(clk), .rst(rst), .satp_ppn(satp_ppn), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_vpn(if_req_vpn), .if_req_ready(if_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_vpn(mem_req_vpn), .mem_req_ready(mem_req_ready),
    .if_resp_valid(if_resp_valid), .mem_resp_valid(mem_resp_valid),
    .resp_pte(resp_pte), .resp_ppn(resp_ppn), .resp_level(resp_level), .resp_fault(resp_fault),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  logic [63:0]       mem [longint unsigned];
  longint unsigned   addr_log [$];
  int unsigned       lat, pend;
  longint unsigned   pend_addr;
  int unsigned       n_vec, n_err;
  bit                last_mem;

  typedef struct packed {
    logic            fault;
    logic [1:0]      level;
    logic [63:0]     pte;
    logic [43:0]     ppn;
    logic [1:0]      n;
    logic [2:0][63:0] addr;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned pt_addr(input longint unsigned base, input logic [26:0] vpn,
                                              input int lvl);
    longint unsigned v = 64'(vpn);
    return base * 4096 + ((v >> (9 * lvl)) % 512) * 8;
  endfunction

  function automatic logic [63:0] rd_mem(input longint unsigned a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] mk(input logic [43:0] ppn, input logic [9:0] fl);
    return {10'b0, ppn, fl};
  endfunction

  function automatic logic [43:0] rand44();
    return 44'({$urandom(), $urandom()});
  endfunction

  // Reference walk: straight from the Sv39 rules, using arithmetic on addresses.
  function automatic exp_t model_walk(input logic [26:0] vpn, input logic [43:0] root);
    exp_t            e;
    longint unsigned a, addr, p, span, v;
    logic [63:0]     pte;
    int              lvl;
    e   = '0;
    a   = 64'(root);
    v   = 64'(vpn);
    lvl = 2;
    for (int step = 0; step < 3; step++) begin
      addr          = pt_addr(a, vpn, lvl);
      pte           = rd_mem(addr);
      e.addr[step]  = addr;
      e.n           = 2'(step + 1);
      e.pte         = pte;
      e.level       = 2'(lvl);
      p             = (pte >> 10) % (64'd1 << 44);
      if (!pte[0] || (!pte[1] && pte[2])) begin
        e.fault = 1'b1;
        return e;
      end
      if (pte[1] || pte[3]) begin
        span    = 64'd1 << (9 * lvl);
        e.fault = (p % span) != 0;
        e.ppn   = 44'(p - p % span + v % span);
        return e;
      end
      if (lvl == 0) begin
        e.fault = 1'b1;
        return e;
      end
      a   = p;
      lvl = lvl - 1;
    end
    return e;
  endfunction

  task automatic build(input logic [26:0] vpn, input logic [43:0] root);
    int              tgt;
    logic [43:0]     a, ppn;
    longint unsigned addr;
    tgt = $urandom_range(0, 3);
    a   = root;
    for (int l = 2; l >= 0; l--) begin
      addr = pt_addr(64'(a), vpn, l);
      if ($urandom_range(0, 9) == 0) begin
        mem[addr] = 64'h0;
        return;
      end
      ppn = rand44();
      if (l == tgt) begin
        if (l > 0 && $urandom_range(0, 3) != 0) ppn = ppn & ~((44'd1 << (9 * l)) - 44'd1);
        mem[addr] = mk(ppn, {2'($urandom()), 4'($urandom()), 3'($urandom_range(1, 7)), 1'b1});
        return;
      end
      mem[addr] = mk(ppn, 10'h001);
      a = ppn;
    end
  endtask

  // Memory responder: returns the PTE `lat` cycles after each accepted read.
  initial begin
    rd_data_valid = 1'b0;
    rd_data       = '0;
    pend          = 0;
    forever begin
      @(posedge clk);
      #1;
      rd_data_valid = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rd_data_valid = 1'b1;
          rd_data       = rd_mem(pend_addr);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && rd_valid && rd_ready) begin
      pend      = lat;
      pend_addr = rd_addr;
      addr_log.push_back(rd_addr);
    end
  end

  task automatic accept(input bit is_mem, input bit chk_rr);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (chk_rr && i == 0) begin
        check("rr_if_ready", 64'(if_req_ready), 64'(!is_mem));
        check("rr_mem_ready", 64'(mem_req_ready), 64'(is_mem));
      end
      if (is_mem ? mem_req_ready : if_req_ready) begin
        @(posedge clk);
        #1;
        if (is_mem) mem_req_valid = 1'b0;
        else        if_req_valid  = 1'b0;
        addr_log.delete();
        last_mem = is_mem;
        return;
      end
    end
    check("accept_timeout", 64'd0, 64'd1);
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit is_mem, input exp_t e, input bit chk_lat);
    int unsigned cyc = 1;
    while (!(if_resp_valid || mem_resp_valid) && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!(if_resp_valid || mem_resp_valid)) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    check("resp_owner", 64'({mem_resp_valid, if_resp_valid}), is_mem ? 64'd2 : 64'd1);
    if (chk_lat) check("resp_latency", 64'(cyc), 64'(2 * int'(e.n) + 1));
    check("resp_fault", 64'(resp_fault), 64'(e.fault));
    check("resp_pte", resp_pte, e.pte);
    if (!e.fault) begin
      check("resp_level", 64'(resp_level), 64'(e.level));
      check("resp_ppn", 64'(resp_ppn), 64'(e.ppn));
    end
    check("rd_count", 64'(addr_log.size()), 64'(e.n));
    for (int i = 0; i < int'(e.n) && i < addr_log.size(); i++)
      check("rd_addr_seq", addr_log[i], e.addr[i]);
    @(posedge clk);
    #1;
    check("resp_one_shot", 64'({mem_resp_valid, if_resp_valid}), 64'd0);
  endtask

  task automatic run_one(input bit is_mem, input logic [26:0] vpn);
    exp_t e;
    e = model_walk(vpn, satp_ppn);
    if (is_mem) begin mem_req_vpn = vpn; mem_req_valid = 1'b1; end
    else        begin if_req_vpn  = vpn; if_req_valid  = 1'b1; end
    accept(is_mem, 1'b0);
    wait_resp(is_mem, e, 1'b1);
  endtask

  task automatic run_both();
    exp_t        ei, em;
    logic [26:0] vi, vm;
    bit          first_mem;
    mem.delete();
    satp_ppn = rand44();
    vi = 27'($urandom());
    vm = 27'($urandom());
    build(vi, satp_ppn);
    build(vm, satp_ppn);
    ei = model_walk(vi, satp_ppn);
    em = model_walk(vm, satp_ppn);
    if_req_vpn    = vi;
    mem_req_vpn   = vm;
    if_req_valid  = 1'b1;
    mem_req_valid = 1'b1;
    first_mem     = !last_mem;
    accept(first_mem, 1'b1);
    wait_resp(first_mem, first_mem ? em : ei, 1'b1);
    accept(!first_mem, 1'b0);
    wait_resp(!first_mem, first_mem ? ei : em, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [26:0] v;
    bit          any_resp;
    int          mode;
    n_vec = 0; n_err = 0; last_mem = 1'b1;
    rst = 1'b1; flush = 1'b0; satp_ppn = ROOT;
    if_req_valid = 1'b0; mem_req_valid = 1'b0; if_req_vpn = '0; mem_req_vpn = '0;
    rd_ready = 1'b1; lat = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_addr", rd_addr, 64'd0);
    check("reset_resp_valid", 64'({mem_resp_valid, if_resp_valid}), 64'd0);
    check("reset_resp_pte", resp_pte, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin from reset: IF first, then MEM, then IF again.
    run_both();
    run_both();

    satp_ppn = ROOT;
    v = 27'h0000400;
    mem.delete();
    mem[pt_addr(ROOT, v, 2)]   = mk(44'h456, 10'h001);
    mem[pt_addr(44'h456, v, 1)] = mk(44'h789, 10'h001);
    mem[pt_addr(44'h789, v, 0)] = mk(44'hABCDE, 10'h0C3);
    run_one(1'b0, v);

    v = 27'h2A5A5A5;
    mem.delete();
    mem[pt_addr(ROOT, v, 2)] = mk(44'h123 << 18, 10'h003);
    run_one(1'b1, v);

    mem.delete();
    run_one(1'b0, 27'h1234567);

    mem[pt_addr(ROOT, v, 2)] = mk(44'h1, 10'h005);
    run_one(1'b0, v);

    mem.delete();
    mem[pt_addr(ROOT, v, 2)]    = mk(44'h456, 10'h001);
    mem[pt_addr(44'h456, v, 1)] = mk(44'h789, 10'h001);
    mem[pt_addr(44'h789, v, 0)] = mk(44'h9, 10'h001);
    run_one(1'b1, v);

    mem.delete();
    mem[pt_addr(ROOT, v, 2)]    = mk(44'h456, 10'h001);
    mem[pt_addr(44'h456, v, 1)] = mk(44'h1001, 10'h003);
    run_one(1'b0, v);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        run_both();
      end else begin
        mem.delete();
        satp_ppn = rand44();
        v = 27'($urandom());
        build(v, satp_ppn);
        run_one(mode == 1, v);
      end
    end

    // Memory back-pressure: request held stable while rd_ready is low.
    satp_ppn = ROOT;
    v = 27'h0000400;
    mem.delete();
    mem[pt_addr(ROOT, v, 2)]    = mk(44'h456, 10'h001);
    mem[pt_addr(44'h456, v, 1)] = mk(44'h789, 10'h001);
    mem[pt_addr(44'h789, v, 0)] = mk(44'hABCDE, 10'h0C3);
    e = model_walk(v, ROOT);
    rd_ready = 1'b0;
    if_req_vpn = v; if_req_valid = 1'b1;
    accept(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("stall_rd_valid", 64'(rd_valid), 64'd1);
      check("stall_rd_addr", rd_addr, e.addr[0]);
      @(posedge clk);
      #1;
    end
    rd_ready = 1'b1;
    wait_resp(1'b0, e, 1'b0);

    // Flush while waiting for data: the late PTE must be swallowed.
    lat = 3;
    if_req_vpn = v; if_req_valid = 1'b1;
    accept(1'b0, 1'b0);
    any_resp = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    any_resp |= if_resp_valid | mem_resp_valid;
    @(posedge clk); #1;
    flush = 1'b0;
    any_resp |= if_resp_valid | mem_resp_valid;
    check("drain_ready_a", 64'(if_req_ready), 64'd0);
    @(posedge clk); #1;
    any_resp |= if_resp_valid | mem_resp_valid;
    check("drain_ready_b", 64'(if_req_ready), 64'd0);
    @(posedge clk); #1;
    any_resp |= if_resp_valid | mem_resp_valid;
    check("drain_ready_after", 64'(if_req_ready), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      any_resp |= if_resp_valid | mem_resp_valid;
    end
    check("flush_no_resp", 64'(any_resp), 64'd0);
    lat = 1;

    // Asynchronous reset in the middle of a walk.
    if_req_vpn = v; if_req_valid = 1'b1;
    accept(1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_addr", rd_addr, 64'd0);
    check("rst_resp_valid", 64'({mem_resp_valid, if_resp_valid}), 64'd0);
    check("rst_resp_pte", resp_pte, 64'd0);
    check("rst_resp_ppn", 64'(resp_ppn), 64'd0);
    check("rst_resp_lvl_flt", 64'({resp_level, resp_fault}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_mem = 1'b1;
    @(posedge clk);
    #1;
    run_both();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
